id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 105 ++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass and a valid/ready handshake.
// Optional define ID_EX_HOLD_SNOOP_EN keeps stalled operands current from the writeback bus.
module id_ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_i,
   input  logic [3:0]  in_af,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [31:0] in_rd_a,
   input  logic [31:0] in_rd_b,
   input  logic [31:0] in_imm,
   input  logic [4:0]  in_dst,
   input  logic        in_wr,
   input  logic        fwd_mem_wr,
   input  logic [4:0]  fwd_mem_dst,
   input  logic [31:0] fwd_mem_data,
   input  logic        fwd_wb_wr,
   input  logic [4:0]  fwd_wb_dst,
   input  logic [31:0] fwd_wb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        i,
   output logic [31:0] SrcA,
   output logic [31:0] SrcB,
   output logic [3:0]  af,
   output logic [4:0]  out_dst,
   output logic        out_wr
);

   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;

   logic          capture;
   logic [DW-1:0] opa;
   logic [DW-1:0] opb;

`ifdef ID_EX_HOLD_SNOOP_EN
   logic [RW-1:0] rs_q;
   logic [RW-1:0] rt_q;
`endif

   assign in_ready = (!out_valid || out_ready) && !flush;
   assign capture  = in_valid && in_ready;

   // Bypass select: EX/MEM result beats MEM/WB, register 0 is never bypassed.
   always_comb begin
      opa = in_rd_a;
      opb = in_rd_b;
      if (fwd_mem_wr && fwd_mem_dst == in_rs && in_rs != RW'(0))
         opa = fwd_mem_data;
      else if (fwd_wb_wr && fwd_wb_dst == in_rs && in_rs != RW'(0))
         opa = fwd_wb_data;
      if (fwd_mem_wr && fwd_mem_dst == in_rt && in_rt != RW'(0))
         opb = fwd_mem_data;
      else if (fwd_wb_wr && fwd_wb_dst == in_rt && in_rt != RW'(0))
         opb = fwd_wb_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         i         <= 1'b0;
         SrcA      <= '0;
         SrcB      <= '0;
         af        <= 4'b0000;
         out_dst   <= '0;
         out_wr    <= 1'b0;
`ifdef ID_EX_HOLD_SNOOP_EN
         rs_q      <= '0;
         rt_q      <= '0;
`endif
      end else if (flush) begin
         out_valid <= 1'b0;
         out_wr    <= 1'b0;
      end else if (capture) begin
         out_valid <= 1'b1;
         i         <= in_i;
         SrcA      <= opa;
         SrcB      <= in_i ? in_imm : opb;
         af        <= in_af;
         out_dst   <= in_dst;
         out_wr    <= in_wr;
`ifdef ID_EX_HOLD_SNOOP_EN
         rs_q      <= in_rs;
         // An immediate instruction has no rt operand; zero disables its snoop.
         rt_q      <= in_i ? RW'(0) : in_rt;
`endif
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
`ifdef ID_EX_HOLD_SNOOP_EN
      end else if (out_valid) begin
         // Stalled: pick up writebacks that would otherwise be missed.
         if (fwd_wb_wr && fwd_wb_dst == rs_q && rs_q != RW'(0))
            SrcA <= fwd_wb_data;
         if (fwd_wb_wr && fwd_wb_dst == rt_q && rt_q != RW'(0))
            SrcB <= fwd_wb_data;
`endif
      end
   end

endmodule
